gray_counter: RTL and testbench
===============================

// Module: gray_counter
// PURPOSE
//  Registered up/down Gray-code counter. It is the upstream stage of the Gray-to-binary converter.
//  Each enabled clock, the output changes by exactly one bit.
//  The output is safe to sample asynchronously or pass across pointer boundaries before conversion.
//  Provides a Gray-coded synchronous load and a terminal-count flag.
// PARAMETERS
//  WIDTH   4   counter width in bits (>=2); count range 0..2^WIDTH-1 (binary-equivalent)
// PORTS
//  clk      in   1      single clock, rising-edge
//  rst_n    in   1      asynchronous active-low reset
//  en       in   1      count enable
//  up_dn    in   1      1 = count up, 0 = count down
//  load     in   1      synchronous load strobe
//  load_g   in   WIDTH  load value, Gray-coded
//  g        out  WIDTH  registered Gray count
//  bin      out  WIDTH  registered binary equivalent of g (same cycle as g)
//  tc       out  1      terminal count (combinational from registered state)
// BEHAVIOUR
//  - Reset: rst_n=0 asynchronously forces g=0, bin=0, tc=0 (tc is also gated by en).
//    Deassertion is taken at the next clk edge.
//  - Internal state is the binary register bin; g is held in its own register.
//  - g is updated each cycle to next_bin ^ (next_bin>>1), so g is glitch-free and never decoded
//    combinationally.
//  - Priority at a rising clk: load > en > hold.
//  - load=1: bin <= gray2bin(load_g), g <= load_g; en and up_dn are ignored that cycle.
//  - gray2bin: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] for i=W-2..0.
//  - load=0, en=1, up_dn=1: bin <= bin+1, modulo 2^WIDTH.
//  - load=0, en=1, up_dn=0: bin <= bin-1, modulo 2^WIDTH.
//  - load=0, en=0: hold; g and bin unchanged.
//  - Latency: 1 clk from load/en sample to the new g/bin.
//  - Successive enabled counts differ in exactly 1 bit of g, including across the wrap.
//  - tc = en & ~load & (up_dn ? bin=={WIDTH{1'b1}} : bin==0).
//    tc flags that the next enabled edge wraps (or saturates, see CONFIGURATION).
//  - Wrap up: bin 2^W-1 -> 0 (g 100..0 -> 000..0). Wrap down: bin 0 -> 2^W-1.
//  - up_dn may change on any cycle; the new direction takes effect on the same edge it is sampled.
//  - Reset mid-count overrides everything immediately. No state survives reset.
// CONFIGURATION
//  GRAY_CNT_SAT_EN defined:
//  - Saturating counter. With en=1, up at bin=2^W-1 holds, and down at bin=0 holds.
//  - tc behaves as above and stays high while parked at the limit with en=1.
//  - load still overrides saturation.
//  GRAY_CNT_SAT_EN undefined (default):
//  - Modulo wrap as described in BEHAVIOUR. No other differences.
// TESTING (WIDTH=4)
//  1. Reset: rst_n=0 mid-count asynchronously -> g=0000, bin=0000, tc=0 before the next clk edge.
//  2. Count up, en=1, up_dn=1, from 0 for 16 clks -> g = 0000,0001,0011,0010,0110,0111,0101,0100,
//     1100,1101,1111,1110,1010,1011,1001,1000.
//     tc=1 only at bin=1111 (g=1000). The next edge gives g=0000 (wrap), or holds 1000 with SAT.
//  3. Count down from 0, en=1, up_dn=0: tc=1 at bin=0.
//     Next edge -> bin=1111, g=1000 (wrap); with SAT, g stays 0000.
//  4. Load priority: load=1, load_g=0110, en=1, up_dn=1 -> next g=0110, bin=0100.
//     The count continues next cycle to g=0111, bin=0101.
//  5. Hold and direction flip: at g=0111, en=0 for 3 clks -> g stays 0111, tc=0.
//     Then en=1, up_dn=0 -> g=0110, bin=0100.
//  6. Every enabled step -> $countones(g_prev ^ g)==1, and bin == gray2bin(g) on every cycle.

Source files
------------

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with Gray-coded synchronous load and terminal-count flag.
// Define GRAY_CNT_SAT_EN to make the count saturate at its limits instead of wrapping.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_g,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] bin,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] next_bin;
  logic             at_max;
  logic             at_min;

  assign at_max = (bin == CNT_MAX);
  assign at_min = (bin == '0);

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    load_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_bin[i] = ^(load_g >> i);
    end
  end

  always_comb begin
    next_bin = bin;
    if (load) begin
      next_bin = load_bin;
    end else if (en) begin
      if (up_dn) begin
`ifdef GRAY_CNT_SAT_EN
        if (!at_max) next_bin = bin + CNT_ONE;
`else
        next_bin = bin + CNT_ONE;
`endif
      end else begin
`ifdef GRAY_CNT_SAT_EN
        if (!at_min) next_bin = bin - CNT_ONE;
`else
        next_bin = bin - CNT_ONE;
`endif
      end
    end
  end

  // g has its own register so it never glitches through a decode path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin <= '0;
      g   <= '0;
    end else begin
      bin <= next_bin;
      g   <= load ? load_g : (next_bin ^ (next_bin >> 1));
    end
  end

  assign tc = rst_n & en & ~load & (up_dn ? at_max : at_min);

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH=4): directed spec scenarios plus randomized
// traffic against a table-driven reference model.
module tb_gray_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_g;
  logic [3:0] g;
  logic [3:0] bin;
  logic       tc;

  int n_checks;
  int n_fail;
  int mb;          // model binary count
  logic [3:0] gray_tbl [16];

  gray_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_g(load_g), .g(g), .bin(bin), .tc(tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bin_of_gray(input logic [3:0] gv);
    for (int k = 0; k < 16; k++) if (gray_tbl[k] == gv) return k;
    return 0;
  endfunction

  function automatic int model_tc();
    if (!rst_n || !en || load) return 0;
    return up_dn ? int'(mb == 15) : int'(mb == 0);
  endfunction

  task automatic apply(input logic l, input logic [3:0] lg, input logic e, input logic u);
    load = l; load_g = lg; en = e; up_dn = u;
    #1;
  endtask

  // Advance the model with the current inputs, then take one clock edge.
  task automatic tick();
    if (load) mb = bin_of_gray(load_g);
    else if (en) begin
`ifdef GRAY_CNT_SAT_EN
      if (up_dn) mb = (mb == 15) ? 15 : mb + 1;
      else       mb = (mb == 0) ? 0 : mb - 1;
`else
      mb = up_dn ? (mb + 1) % 16 : (mb + 15) % 16;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(1'b0, 4'b0000, 1'b1, 1'b0);
    n_checks++;
    if (g !== 4'b0000 || bin !== 4'b0000) begin
      n_fail++; $display("FAIL reset_state: g=%b bin=%b expected 0000/0000", g, bin);
    end
    n_checks++;
    if (tc !== 1'b0) begin
      n_fail++; $display("FAIL reset_tc: tc=%b expected 0", tc);
    end
    @(posedge clk); #1;
    n_checks++;
    if (g !== 4'b0000 || tc !== 1'b0) begin
      n_fail++; $display("FAIL reset_held: g=%b tc=%b expected 0000/0", g, tc);
    end
    rst_n = 1'b1;
    mb = 0;
    apply(1'b0, 4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_count_up();
    logic [3:0] prev;
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 4'b0000, 1'b1, 1'b1);
      n_checks++;
      if (tc !== 1'(model_tc())) begin
        n_fail++; $display("FAIL up_tc step %0d: tc=%b expected %0d", i, tc, model_tc());
      end
      prev = g;
      tick();
      n_checks++;
      if (g !== gray_tbl[mb] || bin !== 4'(mb)) begin
        n_fail++; $display("FAIL up_value step %0d: g=%b bin=%b expected %b/%0d", i, g, bin, gray_tbl[mb], mb);
      end
      if (prev != g || i != 15) begin
        n_checks++;
        if ($countones(prev ^ g) != 1) begin
          n_fail++; $display("FAIL up_onebit step %0d: %b -> %b", i, prev, g);
        end
      end
    end
`ifdef GRAY_CNT_SAT_EN
    n_checks++;
    if (g !== 4'b1000) begin
      n_fail++; $display("FAIL up_sat: g=%b expected 1000", g);
    end
`else
    n_checks++;
    if (g !== 4'b0000) begin
      n_fail++; $display("FAIL up_wrap: g=%b expected 0000", g);
    end
`endif
  endtask

  task automatic test_count_down();
    apply(1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    apply(1'b0, 4'b0000, 1'b1, 1'b0);
    n_checks++;
    if (tc !== 1'b1) begin
      n_fail++; $display("FAIL down_tc: tc=%b expected 1 at bin=%b", tc, bin);
    end
    tick();
`ifdef GRAY_CNT_SAT_EN
    n_checks++;
    if (g !== 4'b0000 || bin !== 4'b0000 || tc !== 1'b1) begin
      n_fail++; $display("FAIL down_sat: g=%b bin=%b tc=%b expected 0000/0000/1", g, bin, tc);
    end
`else
    n_checks++;
    if (g !== 4'b1000 || bin !== 4'b1111) begin
      n_fail++; $display("FAIL down_wrap: g=%b bin=%b expected 1000/1111", g, bin);
    end
`endif
  endtask

  task automatic test_load();
    apply(1'b1, 4'b0110, 1'b1, 1'b1);
    n_checks++;
    if (tc !== 1'b0) begin
      n_fail++; $display("FAIL load_tc: tc=%b expected 0 while loading", tc);
    end
    tick();
    n_checks++;
    if (g !== 4'b0110 || bin !== 4'b0100 || mb != 4) begin
      n_fail++; $display("FAIL load_value: g=%b bin=%b expected 0110/0100", g, bin);
    end
    apply(1'b0, 4'b0000, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (g !== 4'b0111 || bin !== 4'b0101) begin
      n_fail++; $display("FAIL load_continue: g=%b bin=%b expected 0111/0101", g, bin);
    end
  endtask

  task automatic test_hold_flip();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 4'b0000, 1'b0, 1'(i & 1));
      n_checks++;
      if (tc !== 1'b0) begin
        n_fail++; $display("FAIL hold_tc cycle %0d: tc=%b expected 0", i, tc);
      end
      tick();
      n_checks++;
      if (g !== 4'b0111 || bin !== 4'b0101) begin
        n_fail++; $display("FAIL hold_value cycle %0d: g=%b bin=%b expected 0111/0101", i, g, bin);
      end
    end
    apply(1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (g !== 4'b0110 || bin !== 4'b0100) begin
      n_fail++; $display("FAIL flip_down: g=%b bin=%b expected 0110/0100", g, bin);
    end
  endtask

  task automatic test_random();
    logic [3:0] prev;
    int pb;
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      n_checks++;
      if (tc !== 1'(model_tc())) begin
        n_fail++; $display("FAIL rand_tc iter %0d: tc=%b expected %0d", i, tc, model_tc());
      end
      prev = g;
      pb = mb;
      tick();
      n_checks++;
      if (g !== gray_tbl[mb] || bin !== 4'(mb)) begin
        n_fail++; $display("FAIL rand_value iter %0d: g=%b bin=%b expected %b/%0d", i, g, bin, gray_tbl[mb], mb);
      end
      if (!load && en && pb != mb) begin
        n_checks++;
        if ($countones(prev ^ g) != 1) begin
          n_fail++; $display("FAIL rand_onebit iter %0d: %b -> %b", i, prev, g);
        end
      end
    end
  endtask

  task automatic test_reset_midcount();
    apply(1'b1, 4'b1101, 1'b1, 1'b1);
    tick();
    apply(1'b0, 4'b0000, 1'b1, 1'b1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (g !== 4'b0000 || bin !== 4'b0000 || tc !== 1'b0) begin
      n_fail++; $display("FAIL reset_midcount: g=%b bin=%b tc=%b expected 0000/0000/0", g, bin, tc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mb = 0;
    apply(1'b0, 4'b0000, 1'b1, 1'b1);
    tick();
    n_checks++;
    if (g !== 4'b0001 || bin !== 4'b0001) begin
      n_fail++; $display("FAIL reset_release: g=%b bin=%b expected 0001/0001", g, bin);
    end
  endtask

  initial begin
    gray_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    n_checks = 0;
    n_fail = 0;
    mb = 0;
    rst_n = 1'b0;
    en = 1'b0; up_dn = 1'b0; load = 1'b0; load_g = 4'b0000;
    @(posedge clk); #1;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold_flip();
    test_random();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
